keypad_matrix_scanner: RTL and testbench

Input-side counterpart to the LED scanner. The LED scanner walks a pattern across output pins; this block walks an active-low strobe across the columns of a 4x4 key matrix and reads back the rows. It synchronises, frames and debounces the readings, then reports one-hot key presses as a 4-bit key code with a single-cycle valid strobe. It sits between the board's keypad pins and any control logic, for example logic that changes scanner direction or speed.

---
 rtl/keypad_matrix_scanner_if.sv | 25 ++
 rtl/keypad_matrix_scanner.sv | 205 ++++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_matrix_scanner_if.sv
// Keypad pin/event bundle: column strobes and row sense toward the matrix,
// debounced key events toward the consuming logic.
interface keypad_matrix_scanner_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (
    output col_n,
    input  row_n,
    output key_code,
    output key_valid,
    output key_down
  );

  modport slave (
    input  col_n,
    output row_n,
    input  key_code,
    input  key_valid,
    input  key_down
  );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: strobes columns, debounces full-matrix frames, emits key events.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_matrix_scanner #(
  parameter int SCAN_DIV        = 1024,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 32
) (
  input  logic                      hwclk,
  input  logic                      rst,
  keypad_matrix_scanner_if.master   kp
);

  localparam int                 DIV_W      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]   DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]         DB_LAST    = 8'(DEBOUNCE_FRAMES);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [7:0]         REP_LAST   = 8'(REPEAT_FRAMES);
`endif

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  logic [3:0]       r_row_p0, r_row_p1;
  logic [DIV_W-1:0] r_dwell;
  logic [1:0]       r_col;
  logic [3:0]       r_col_n;
  logic [11:0]      r_frame;
  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cand, w_cand_nxt;
  logic [7:0]       r_db_cnt, w_db_nxt;
  logic [3:0]       r_key_code, w_code_nxt;
  logic             r_key_valid, w_valid_nxt;
  logic             r_key_down, w_down_nxt;
  logic             w_accept;
`ifdef KEYPAD_REPEAT_EN
  logic [7:0]       r_rep_cnt, w_rep_nxt;
`endif

  logic [3:0]  w_rows;
  logic        w_sample;
  logic        w_frame_done;
  logic [15:0] w_frame_full;
  logic [4:0]  w_pop;
  logic [3:0]  w_k;
  logic        w_none, w_single;

  assign w_rows       = ~r_row_p1;
  assign w_sample     = (r_dwell == DWELL_LAST);
  assign w_frame_done = w_sample && (r_col == 2'd3);
  // Column 3 is classified from the live sample, so the decision lands on its sample cycle
  assign w_frame_full = {w_rows, r_frame};

  // Stage p0/p1: row synchroniser, column dwell and frame capture
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      r_row_p0 <= 4'hF;
      r_row_p1 <= 4'hF;
      r_dwell  <= '0;
      r_col    <= 2'd0;
      r_col_n  <= 4'b1110;
      r_frame  <= '0;
    end else begin
      r_row_p0 <= kp.row_n;
      r_row_p1 <= r_row_p0;
      if (w_sample) begin
        r_dwell <= '0;
        r_col   <= r_col + 2'd1;
        r_col_n <= {r_col_n[2:0], r_col_n[3]};
        case (r_col)
          2'd0:    r_frame[3:0]  <= w_rows;
          2'd1:    r_frame[7:4]  <= w_rows;
          2'd2:    r_frame[11:8] <= w_rows;
          default: ;
        endcase
      end else begin
        r_dwell <= r_dwell + DIV_W'(1);
      end
    end
  end

  always_comb begin
    w_pop = '0;
    w_k   = '0;
    for (int i = 0; i < 16; i++) begin
      if (w_frame_full[i]) begin
        w_pop = w_pop + 5'd1;
        w_k   = 4'(i);
      end
    end
  end

  assign w_none   = (w_pop == 5'd0);
  assign w_single = (w_pop == 5'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_db_nxt    = r_db_cnt;
    w_code_nxt  = r_key_code;
    w_valid_nxt = 1'b0;
    w_down_nxt  = r_key_down;
    w_accept    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    w_rep_nxt   = r_rep_cnt;
`endif
    if (w_frame_done) begin
      case (r_state)
        IDLE: begin
          if (w_single) begin
            w_cand_nxt = w_k;
            w_db_nxt   = 8'd1;
            if (DB_LAST <= 8'd1) w_accept = 1'b1;
            else                 w_state_nxt = PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (w_single && (w_k == r_cand)) begin
            w_db_nxt = r_db_cnt + 8'd1;
            if (w_db_nxt >= DB_LAST) w_accept = 1'b1;
          end else if (w_single) begin
            w_cand_nxt = w_k;
            w_db_nxt   = 8'd1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        HELD: begin
          if (w_none) begin
            w_db_nxt = 8'd1;
            if (DB_LAST <= 8'd1) begin
              w_state_nxt = IDLE;
              w_down_nxt  = 1'b0;
            end else begin
              w_state_nxt = RELEASE_DB;
            end
          end
`ifdef KEYPAD_REPEAT_EN
          else if (w_single && (w_k == r_key_code)) begin
            if ((r_rep_cnt + 8'd1) >= REP_LAST) begin
              w_valid_nxt = 1'b1;
              w_rep_nxt   = 8'd0;
            end else begin
              w_rep_nxt   = r_rep_cnt + 8'd1;
            end
          end
`endif
        end
        RELEASE_DB: begin
          if (w_none) begin
            w_db_nxt = r_db_cnt + 8'd1;
            if (w_db_nxt >= DB_LAST) begin
              w_state_nxt = IDLE;
              w_down_nxt  = 1'b0;
            end
          end else begin
            w_state_nxt = HELD;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
      if (w_accept) begin
        w_code_nxt  = w_cand_nxt;
        w_valid_nxt = 1'b1;
        w_down_nxt  = 1'b1;
        w_state_nxt = HELD;
`ifdef KEYPAD_REPEAT_EN
        w_rep_nxt   = 8'd0;
`endif
      end
`ifdef KEYPAD_REPEAT_EN
      if (w_state_nxt != HELD) w_rep_nxt = 8'd0;
`endif
    end
  end

  // Stage p2: debounce FSM and event registers
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cand      <= '0;
      r_db_cnt    <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_db_cnt    <= w_db_nxt;
      r_key_code  <= w_code_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_down  <= w_down_nxt;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= w_rep_nxt;
`endif
    end
  end

  assign kp.col_n     = r_col_n;
  assign kp.key_code  = r_key_code;
  assign kp.key_valid = r_key_valid;
  assign kp.key_down  = r_key_down;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner: a small key-matrix model drives the rows.
module tb_keypad_matrix_scanner;

  logic        hwclk = 1'b0;
  logic        rst   = 1'b0;
  logic [15:0] pressed = '0;
  int          tests = 0;
  int          fails = 0;

  int          pulses = 0;
  logic [3:0]  last_code = '0;
  logic        prev_v = 1'b0;
  int          b2b = 0;

  keypad_matrix_scanner_if kp();

  keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3), .REPEAT_FRAMES(2)) dut (
    .hwclk (hwclk),
    .rst   (rst),
    .kp    (kp.master)
  );

  always #5 hwclk = ~hwclk;

  function automatic logic [3:0] rows_for(input logic [15:0] p, input logic [3:0] cn);
    logic [3:0] r;
    r = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!cn[c])
        for (int w = 0; w < 4; w++)
          if (p[c*4+w]) r[w] = 1'b0;
    return r;
  endfunction

  always_comb kp.row_n = rows_for(pressed, kp.col_n);

  always @(negedge hwclk) begin
    if (rst) begin
      prev_v <= 1'b0;
    end else begin
      if (kp.key_valid) begin
        pulses    <= pulses + 1;
        last_code <= kp.key_code;
        if (prev_v) b2b <= b2b + 1;
      end
      prev_v <= kp.key_valid;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  logic [15:0] pressed2 = '0;
  int          pulses2 = 0;
  logic [3:0]  last_code2 = '0;
  keypad_matrix_scanner_if kp2();
  keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(1), .REPEAT_FRAMES(2)) u_rep (
    .hwclk (hwclk),
    .rst   (rst),
    .kp    (kp2.master)
  );
  always_comb kp2.row_n = rows_for(pressed2, kp2.col_n);
  always @(negedge hwclk) begin
    if (!rst && kp2.key_valid) begin
      pulses2    <= pulses2 + 1;
      last_code2 <= kp2.key_code;
    end
  end
`endif

  task automatic run_frames(input int n);
    repeat (16*n) @(negedge hwclk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    tests++; if (kp.col_n !== 4'b1110) begin $display("FAIL reset_col_n: got %b want 1110", kp.col_n); fails++; end
    tests++; if (kp.key_code !== 4'd0) begin $display("FAIL reset_key_code: got %0d want 0", kp.key_code); fails++; end
    tests++; if (kp.key_valid !== 1'b0) begin $display("FAIL reset_key_valid: got %b want 0", kp.key_valid); fails++; end
    tests++; if (kp.key_down !== 1'b0) begin $display("FAIL reset_key_down: got %b want 0", kp.key_down); fails++; end
  endtask

  task automatic test_column_walk();
    logic [3:0] walk [4];
    logic [3:0] exp_cn;
    walk[0] = 4'b1110; walk[1] = 4'b1101; walk[2] = 4'b1011; walk[3] = 4'b0111;
    @(negedge hwclk) rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_cn = walk[(k/4)%4];
      tests++; if (kp.col_n !== exp_cn) begin $display("FAIL col_walk[%0d]: got %b want %b", k, kp.col_n, exp_cn); fails++; end
      @(negedge hwclk);
    end
    #1;
    run_frames(9);
    tests++; if (pulses !== 0) begin $display("FAIL idle_no_valid: got %0d pulses want 0", pulses); fails++; end
    tests++; if (kp.col_n !== 4'b1110) begin $display("FAIL walk_wrap: got %b want 1110", kp.col_n); fails++; end
  endtask

  task automatic test_debounced_press();
    int base;
    base = pulses;
    pressed = 16'(1) << 9;
    run_frames(2);
    tests++; if (pulses - base !== 0) begin $display("FAIL press_early: got %0d pulses want 0", pulses - base); fails++; end
    tests++; if (kp.key_down !== 1'b0) begin $display("FAIL press_early_down: got %b want 0", kp.key_down); fails++; end
    run_frames(1);
    tests++; if (pulses - base !== 1) begin $display("FAIL press_pulse: got %0d pulses want 1", pulses - base); fails++; end
    tests++; if (last_code !== 4'd9) begin $display("FAIL press_code: got %0d want 9", last_code); fails++; end
    tests++; if (kp.key_down !== 1'b1) begin $display("FAIL press_down: got %b want 1", kp.key_down); fails++; end
    run_frames(3);
    tests++; if (pulses - base !== 1) begin $display("FAIL held_single_event: got %0d pulses want 1", pulses - base); fails++; end
    pressed = '0;
    run_frames(2);
    tests++; if (kp.key_down !== 1'b1) begin $display("FAIL release_early_down: got %b want 1", kp.key_down); fails++; end
    run_frames(1);
    tests++; if (kp.key_down !== 1'b0) begin $display("FAIL release_down: got %b want 0", kp.key_down); fails++; end
    tests++; if (pulses - base !== 1) begin $display("FAIL release_no_pulse: got %0d pulses want 1", pulses - base); fails++; end
  endtask

  task automatic test_bounce();
    int base;
    base = pulses;
    pressed = 16'(1) << 5; run_frames(2);
    pressed = '0;          run_frames(1);
    pressed = 16'(1) << 5; run_frames(2);
    tests++; if (pulses - base !== 0) begin $display("FAIL bounce_reject: got %0d pulses want 0", pulses - base); fails++; end
    run_frames(1);
    tests++; if (pulses - base !== 1) begin $display("FAIL bounce_accept: got %0d pulses want 1", pulses - base); fails++; end
    tests++; if (last_code !== 4'd5) begin $display("FAIL bounce_code: got %0d want 5", last_code); fails++; end
    pressed = '0; run_frames(3);
    tests++; if (kp.key_down !== 1'b0) begin $display("FAIL bounce_release: got %b want 0", kp.key_down); fails++; end
  endtask

  task automatic test_ghost();
    int base;
    base = pulses;
    pressed = 16'h8001; run_frames(10);
    tests++; if (pulses - base !== 0) begin $display("FAIL ghost_no_event: got %0d pulses want 0", pulses - base); fails++; end
    tests++; if (kp.key_down !== 1'b0) begin $display("FAIL ghost_down: got %b want 0", kp.key_down); fails++; end
    pressed = 16'h0010; run_frames(3);
    tests++; if (pulses - base !== 1 || last_code !== 4'd4) begin $display("FAIL ghost_first_key: got %0d pulses code %0d want 1 code 4", pulses - base, last_code); fails++; end
    pressed = 16'h0050; run_frames(4);
    pressed = 16'h0040; run_frames(2);
    tests++; if (pulses - base !== 1) begin $display("FAIL ghost_second_key: got %0d pulses want 1", pulses - base); fails++; end
    tests++; if (kp.key_code !== 4'd4 || kp.key_down !== 1'b1) begin $display("FAIL ghost_held: got code %0d down %b want 4 1", kp.key_code, kp.key_down); fails++; end
    pressed = '0; run_frames(2);
    tests++; if (kp.key_down !== 1'b1) begin $display("FAIL ghost_release_early: got %b want 1", kp.key_down); fails++; end
    run_frames(1);
    tests++; if (kp.key_down !== 1'b0) begin $display("FAIL ghost_release: got %b want 0", kp.key_down); fails++; end
  endtask

  task automatic test_release_abort();
    int base;
    base = pulses;
    pressed = 16'h0004; run_frames(3);
    pressed = '0;       run_frames(2);
    pressed = 16'h0004; run_frames(1);
    tests++; if (kp.key_down !== 1'b1 || pulses - base !== 1) begin $display("FAIL abort_reheld: got down %b pulses %0d want 1 1", kp.key_down, pulses - base); fails++; end
    pressed = '0; run_frames(2);
    tests++; if (kp.key_down !== 1'b1) begin $display("FAIL abort_restart_db: got %b want 1", kp.key_down); fails++; end
    run_frames(1);
    tests++; if (kp.key_down !== 1'b0 || pulses - base !== 1) begin $display("FAIL abort_release: got down %b pulses %0d want 0 1", kp.key_down, pulses - base); fails++; end
    tests++; if (b2b !== 0) begin $display("FAIL valid_back_to_back: got %0d doubled pulses want 0", b2b); fails++; end
  endtask

  task automatic test_reset_mid_debounce();
    int base;
    base = pulses;
    pressed = 16'h0080;
    run_frames(2);
    repeat (5) @(negedge hwclk);
    #1 rst = 1'b1;
    #1;
    tests++; if (kp.col_n !== 4'b1110) begin $display("FAIL async_rst_col_n: got %b want 1110", kp.col_n); fails++; end
    tests++; if (kp.key_code !== 4'd0) begin $display("FAIL async_rst_code: got %0d want 0", kp.key_code); fails++; end
    tests++; if (kp.key_valid !== 1'b0 || kp.key_down !== 1'b0) begin $display("FAIL async_rst_flags: got valid %b down %b want 0 0", kp.key_valid, kp.key_down); fails++; end
    repeat (2) @(negedge hwclk);
    rst = 1'b0;
    run_frames(2);
    tests++; if (pulses - base !== 0 || kp.key_down !== 1'b0) begin $display("FAIL rst_fresh_db: got pulses %0d down %b want 0 0", pulses - base, kp.key_down); fails++; end
    run_frames(1);
    tests++; if (pulses - base !== 1 || last_code !== 4'd7) begin $display("FAIL rst_accept: got pulses %0d code %0d want 1 7", pulses - base, last_code); fails++; end
    pressed = '0; run_frames(3);
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_auto_repeat();
    int base;
    int exp_n;
    base = pulses2;
    pressed2 = 16'h0008;
    for (int f = 1; f <= 7; f++) begin
      run_frames(1);
      exp_n = (f + 1) / 2;
      tests++; if (pulses2 - base !== exp_n || last_code2 !== 4'd3) begin $display("FAIL repeat_frame%0d: got pulses %0d code %0d want %0d code 3", f, pulses2 - base, last_code2, exp_n); fails++; end
    end
    pressed2 = '0; run_frames(2);
  endtask
`endif

  initial begin
    test_reset();
    test_column_walk();
    test_debounced_press();
    test_bounce();
    test_ghost();
    test_release_abort();
    test_reset_mid_debounce();
`ifdef KEYPAD_REPEAT_EN
    test_auto_repeat();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
